// File: rtl/qubit_stream_encoder_if.sv
// Block-in / beat-out bundle for the BB84 polarisation encoder.
// slave is the encoder's view; master is the feeding/draining side.
interface qubit_stream_encoder_if #(
  parameter int N_BITS = 80,
  parameter int LANES  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] r_bit;
  logic [N_BITS-1:0] r_base;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [2*LANES-1:0] out_sym;
  logic              out_last;

  modport slave (
    input  in_valid, r_bit, r_base, mode, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );

  modport master (
    output in_valid, r_bit, r_base, mode, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/qubit_stream_encoder.sv
// BB84 polarisation encoder: captures one block of bit/basis pairs,
// streams it out LANES symbols per beat with backpressure.
module qubit_stream_encoder #(
  parameter int N_BITS = 80,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qubit_stream_encoder_if.slave bus,
  output logic [CNT_W-1:0]      blk_cnt,
  output logic                  busy
);
  localparam int SW    = 2 * LANES;
  localparam int BEATS = N_BITS / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  if (N_BITS % LANES != 0) begin : g_bad_cfg
    $error("N_BITS must be a multiple of LANES");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [2*N_BITS-1:0] sym_q, sym_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [N_BITS-1:0]   base_eff;
  logic [2*N_BITS-1:0] enc;

  always_comb begin
    base_eff = bus.r_base;
    unique case (1'b1)
      (bus.mode == 2'b01): base_eff = '0;
      (bus.mode == 2'b10): base_eff = '1;
      default: ;
    endcase
    enc = '0;
    for (int i = 0; i < N_BITS; i++) begin
      enc[2*i +: 2] = {base_eff[i], bus.r_bit[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sym_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held block shifts down one beat per transfer, so it drains to zero.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sym_d   = enc;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          sym_d = sym_q >> SW;
          if (beat_q == LAST) begin
            cnt_d   = cnt_q + 1'b1;
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == SEND);
    bus.out_last  = (state_q == SEND) && (beat_q == LAST);
    bus.out_sym   = sym_q[SW-1:0];
    busy          = (state_q == SEND);
    blk_cnt       = cnt_q;
  end
endmodule

// File: tb/tb_qubit_stream_encoder.sv
// Bench for qubit_stream_encoder: vector table, corner sequences,
// random blocks against a symbol-list reference model.
module tb_qubit_stream_encoder;
  localparam int N  = 80;
  localparam int L  = 4;
  localparam int NB = N / L;

  typedef logic [7:0] beats_t [NB];

  typedef struct {
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic [1:0]   m;
    logic [7:0]   beat0;
    logic [7:0]   rest;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [15:0] blk_cnt;
  logic        busy;
  logic [2:0]  blk_cnt2;
  logic        busy2;

  int n_cmp;
  int n_bad;
  int exp_cnt;

  qubit_stream_encoder_if #(.N_BITS(N), .LANES(L)) bus ();
  qubit_stream_encoder_if #(.N_BITS(N), .LANES(L)) bus2 ();

  qubit_stream_encoder #(.N_BITS(N), .LANES(L), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .blk_cnt(blk_cnt), .busy(busy)
  );

  qubit_stream_encoder #(.N_BITS(N), .LANES(L), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .blk_cnt(blk_cnt2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: list of symbols, packed LANES per beat, lane 0 lowest.
  function automatic beats_t model(input logic [N-1:0] b,
                                   input logic [N-1:0] s,
                                   input logic [1:0] m);
    beats_t r;
    for (int k = 0; k < NB; k++) begin
      r[k] = 8'h00;
      for (int j = 0; j < L; j++) begin
        int i;
        int base;
        int sym;
        i    = k * L + j;
        base = (m == 2'b01) ? 0 : (m == 2'b10) ? 1 : int'(s[i]);
        sym  = base * 2 + int'(b[i]);
        r[k] = r[k] | 8'(sym << (2 * j));
      end
    end
    return r;
  endfunction

  task automatic accept(input logic [N-1:0] b,
                        input logic [N-1:0] s,
                        input logic [1:0] m,
                        input bit hold_valid,
                        input bit scramble,
                        input string tag);
    @(posedge clk); #1;
    bus.r_bit    = b;
    bus.r_base   = s;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk({tag, " pre in_ready"}, 32'(bus.in_ready), 1);
    chk({tag, " pre out_valid"}, 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    if (!hold_valid) bus.in_valid = 1'b0;
    if (scramble) begin
      bus.r_bit  = ~b;
      bus.r_base = ~s;
      bus.mode   = m ^ 2'b11;
    end
  endtask

  task automatic stream_check(input beats_t ex,
                              input int stall_at,
                              input int stall_n,
                              input int nbeats,
                              input string tag);
    int beat;
    int stalls;
    int guard;
    beat   = 0;
    stalls = 0;
    guard  = 0;
    while (beat < nbeats && guard < nbeats + stall_n + 4) begin
      guard++;
      bus.out_ready = (beat == stall_at && stalls < stall_n) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk($sformatf("%s b%0d valid", tag, beat), 32'(bus.out_valid), 1);
      chk($sformatf("%s b%0d sym", tag, beat), 32'(bus.out_sym), 32'(ex[beat]));
      chk($sformatf("%s b%0d last", tag, beat), 32'(bus.out_last),
          32'(beat == NB - 1));
      chk($sformatf("%s b%0d busy", tag, beat), 32'(busy), 1);
      if (bus.out_ready) beat++;
      else stalls++;
      @(posedge clk); #1;
    end
    if (beat < nbeats) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got %0d beats required %0d", tag, beat, nbeats);
    end
  endtask

  task automatic post_check(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " idle in_ready"}, 32'(bus.in_ready), 1);
    chk({tag, " idle out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, " idle last"}, 32'(bus.out_last), 0);
    chk({tag, " idle sym"}, 32'(bus.out_sym), 0);
    chk({tag, " idle busy"}, 32'(busy), 0);
    chk({tag, " blk_cnt"}, 32'(blk_cnt), 32'(exp_cnt));
    @(negedge clk);
    chk({tag, " idle2 out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, " idle2 blk_cnt"}, 32'(blk_cnt), 32'(exp_cnt));
  endtask

  initial begin
    vec_t   vt [6];
    beats_t ex;
    beats_t exb;
    logic [N-1:0] ones;
    logic [N-1:0] a_b, a_s, b_b, b_s;
    int done;

    n_cmp   = 0;
    n_bad   = 0;
    exp_cnt = 0;
    ones    = '1;

    vt[0] = '{b: '0, s: '0, m: 2'b00, beat0: 8'h00, rest: 8'h00};
    vt[1] = '{b: 80'hA, s: 80'hC, m: 2'b00, beat0: 8'hE4, rest: 8'h00};
    vt[2] = '{b: ones, s: ones, m: 2'b01, beat0: 8'h55, rest: 8'h55};
    vt[3] = '{b: '0, s: '0, m: 2'b10, beat0: 8'hAA, rest: 8'hAA};
    vt[4] = '{b: ones, s: ones, m: 2'b11, beat0: 8'hFF, rest: 8'hFF};
    vt[5] = '{b: ones, s: '0, m: 2'b10, beat0: 8'hFF, rest: 8'hFF};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mode = 2'b00;
    bus.r_bit = '0; bus.r_base = '0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.mode = 2'b00;
    bus2.r_bit = '0; bus2.r_base = '0;
    #3;
    chk("rst in_ready", 32'(bus.in_ready), 1);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_last", 32'(bus.out_last), 0);
    chk("rst out_sym", 32'(bus.out_sym), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst blk_cnt", 32'(blk_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors; mode/data scrambled after accept must not matter.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < NB; k++) ex[k] = (k == 0) ? vt[v].beat0 : vt[v].rest;
      accept(vt[v].b, vt[v].s, vt[v].m, 1'b0, v >= 2, $sformatf("vec%0d", v));
      stream_check(ex, -1, 0, NB, $sformatf("vec%0d", v));
      exp_cnt++;
      post_check($sformatf("vec%0d", v));
    end

    // Backpressure at beat 3 for 5 cycles.
    for (int k = 0; k < NB; k++) ex[k] = (k == 0) ? 8'hE4 : 8'h00;
    accept(80'hA, 80'hC, 2'b00, 1'b0, 1'b0, "stall");
    stream_check(ex, 3, 5, NB, "stall");
    exp_cnt++;
    post_check("stall");

    // Asynchronous reset in the middle of beat 7.
    ex = model(80'h1234_5678_9ABC_DEF0_1357, 80'hFEDC_BA98_7654_3210_2468, 2'b00);
    accept(80'h1234_5678_9ABC_DEF0_1357, 80'hFEDC_BA98_7654_3210_2468,
           2'b00, 1'b0, 1'b0, "abort");
    stream_check(ex, -1, 0, 7, "abort");
    #2;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    chk("abort out_valid", 32'(bus.out_valid), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort blk_cnt", 32'(blk_cnt), 0);
    chk("abort in_ready", 32'(bus.in_ready), 1);
    chk("abort out_sym", 32'(bus.out_sym), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    accept(80'h1234_5678_9ABC_DEF0_1357, 80'hFEDC_BA98_7654_3210_2468,
           2'b00, 1'b0, 1'b0, "after_rst");
    stream_check(ex, -1, 0, NB, "after_rst");
    exp_cnt++;
    post_check("after_rst");

    // in_valid held: B waits for the bubble after A.
    a_b = 80'hF0F0_0F0F_AAAA_5555_C3C3;
    a_s = 80'h0123_4567_89AB_CDEF_FFFF;
    b_b = 80'h1111_2222_3333_4444_5555;
    b_s = 80'h9999_0000_FFFF_0000_9999;
    ex  = model(a_b, a_s, 2'b00);
    exb = model(b_b, b_s, 2'b10);
    accept(a_b, a_s, 2'b00, 1'b1, 1'b0, "blkA");
    bus.r_bit  = b_b;
    bus.r_base = b_s;
    bus.mode   = 2'b10;
    stream_check(ex, -1, 0, NB, "blkA");
    exp_cnt++;
    @(negedge clk);
    chk("bubble in_ready", 32'(bus.in_ready), 1);
    chk("bubble out_valid", 32'(bus.out_valid), 0);
    chk("bubble blk_cnt", 32'(blk_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    stream_check(exb, -1, 0, NB, "blkB");
    exp_cnt++;
    post_check("blkB");

    // Random blocks, modes and stalls against the model.
    for (int r = 0; r < 10; r++) begin
      logic [N-1:0] rb, rs;
      logic [1:0]   rm;
      int sa, sn;
      rb = N'({$urandom(), $urandom(), $urandom()});
      rs = N'({$urandom(), $urandom(), $urandom()});
      rm = 2'($urandom_range(3, 0));
      sa = int'($urandom_range(NB - 1, 0));
      sn = int'($urandom_range(4, 0));
      ex = model(rb, rs, rm);
      accept(rb, rs, rm, 1'b0, 1'b1, $sformatf("rnd%0d", r));
      stream_check(ex, sa, sn, NB, $sformatf("rnd%0d", r));
      exp_cnt++;
      post_check($sformatf("rnd%0d", r));
    end

    // Counter wrap on a narrow-counter instance, back-to-back blocks.
    done = 0;
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    for (int c = 0; c < 400 && done < 8; c++) begin
      logic lt;
      @(negedge clk);
      lt = bus2.out_valid & bus2.out_last;
      @(posedge clk); #1;
      if (lt) begin
        done++;
        if (done == 7) chk("wrap cnt7", 32'(blk_cnt2), 7);
      end
    end
    bus2.in_valid = 1'b0;
    chk("wrap blocks", 32'(done), 8);
    @(negedge clk);
    chk("wrap cnt0", 32'(blk_cnt2), 0);
    chk("wrap idle", 32'(busy2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
